// File: rtl/wave_capture_if.sv
// Sample-in / RAM-write bundle between the audio front end, the capture sequencer and the waveform RAM.
interface wave_capture_if #(
    parameter int SAMPLE_W   = 16,
    parameter int FRAME_LOG2 = 8
);
    logic                  new_sample_ready;
    logic [SAMPLE_W-1:0]   new_sample_in;
    logic                  wave_display_idle;
    logic [FRAME_LOG2:0]   write_address;
    logic                  write_enable;
    logic [7:0]            write_sample;
    logic                  read_index;
    logic [1:0]            capture_state;

    modport master (
        output new_sample_ready,
        output new_sample_in,
        output wave_display_idle,
        input  write_address,
        input  write_enable,
        input  write_sample,
        input  read_index,
        input  capture_state
    );

    modport slave (
        input  new_sample_ready,
        input  new_sample_in,
        input  wave_display_idle,
        output write_address,
        output write_enable,
        output write_sample,
        output read_index,
        output capture_state
    );
endinterface

// File: rtl/wave_capture_ctrl.sv
// Zero-crossing triggered, double-buffered frame capture into the waveform sample RAM.
// Optional forced trigger after TIMEOUT_SAMPLES quiet samples: define WAVE_CAPTURE_TIMEOUT_EN.
module wave_capture_ctrl #(
    parameter int SAMPLE_W        = 16,
    parameter int FRAME_LOG2      = 8,
    parameter int TIMEOUT_SAMPLES = 1024
) (
    input logic           clk,
    input logic           reset,
    wave_capture_if.slave bus
);

    typedef enum logic [1:0] {
        ST_ARMED  = 2'b00,
        ST_ACTIVE = 2'b01,
        ST_WAIT   = 2'b10
    } state_t;

    state_t                state_q, state_d;
    logic [FRAME_LOG2-1:0] count_q, count_d;
    logic                  read_index_q, read_index_d;
    logic                  prev_neg_q;
    logic                  accept;
    logic                  trigger;
    logic                  sample_neg;

    logic                  write_enable_q;
    logic [FRAME_LOG2:0]   write_address_q;
    logic [7:0]            write_sample_q;

    assign sample_neg = bus.new_sample_in[SAMPLE_W-1];

    // Only the top byte of the sample reaches the RAM.
    logic unused_low_bits;
    assign unused_low_bits = ^bus.new_sample_in[SAMPLE_W-9:0];

`ifdef WAVE_CAPTURE_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_SAMPLES > 1) ? $clog2(TIMEOUT_SAMPLES) : 1;

    logic [TO_W-1:0] timeout_q;
    logic            timeout_hit;

    assign timeout_hit = bus.new_sample_ready && (timeout_q == TO_W'(TIMEOUT_SAMPLES - 1));
    assign trigger     = (bus.new_sample_ready && prev_neg_q && !sample_neg) || timeout_hit;

    // Held at zero outside ARMED, so it starts fresh every time ARMED is entered.
    always_ff @(posedge clk) begin
        if (reset || state_q != ST_ARMED || trigger) begin
            timeout_q <= '0;
        end else if (bus.new_sample_ready) begin
            timeout_q <= timeout_q + 1'b1;
        end
    end
`else
    assign trigger = bus.new_sample_ready && prev_neg_q && !sample_neg;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_ARMED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        read_index_d = read_index_q;
        accept       = 1'b0;

        case (state_q)
            ST_ARMED: begin
                if (trigger) begin
                    accept  = 1'b1;
                    count_d = FRAME_LOG2'(1);
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (bus.new_sample_ready) begin
                    accept = 1'b1;
                    if (&count_q) begin
                        count_d = '0;
                        state_d = ST_WAIT;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (bus.wave_display_idle) begin
                    read_index_d = ~read_index_q;
                    state_d      = ST_ARMED;
                end
            end
            default: begin
                count_d = '0;
                state_d = ST_ARMED;
            end
        endcase
    end

    // Write port is registered; the address half is latched from read_index at accept time.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q         <= '0;
            read_index_q    <= 1'b0;
            prev_neg_q      <= 1'b0;
            write_enable_q  <= 1'b0;
            write_address_q <= '0;
            write_sample_q  <= '0;
        end else begin
            count_q        <= count_d;
            read_index_q   <= read_index_d;
            write_enable_q <= accept;
            if (bus.new_sample_ready) begin
                prev_neg_q <= sample_neg;
            end
            if (accept) begin
                write_address_q <= {~read_index_q, count_q};
                write_sample_q  <= {~sample_neg, bus.new_sample_in[SAMPLE_W-2 -: 7]};
            end
        end
    end

    assign bus.write_enable  = write_enable_q;
    assign bus.write_address = write_address_q;
    assign bus.write_sample  = write_sample_q;
    assign bus.read_index    = read_index_q;
    assign bus.capture_state = state_q;

endmodule

// File: tb/tb_wave_capture_ctrl.sv
// Directed bench for wave_capture_ctrl: vector table for triggering and data mapping, plus frame sequences.
module tb_wave_capture_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    wave_capture_if #(.SAMPLE_W(16), .FRAME_LOG2(8)) bus ();

    wave_capture_ctrl #(
        .SAMPLE_W       (16),
        .FRAME_LOG2     (8),
        .TIMEOUT_SAMPLES(1024)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic [15:0] smp;
        logic        idle;
        logic        we;
        logic [8:0]  addr;
        logic [7:0]  data;
        logic [1:0]  st;
        logic        ri;
    } vec_t;

    vec_t vecs [10];

    // Drive one cycle of inputs, then sample the registered outputs just after the edge.
    task automatic applyStimulus(input logic rdy, input logic [15:0] smp, input logic idle);
        @(negedge clk);
        bus.new_sample_ready  = rdy;
        bus.new_sample_in     = smp;
        bus.wave_display_idle = idle;
        @(posedge clk);
        #1;
        bus.new_sample_ready  = 1'b0;
        bus.wave_display_idle = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic we, input logic [8:0] addr,
                               input logic [7:0] data, input logic [1:0] st, input logic ri);
        logic bad;
        bad = (bus.write_enable !== we) || (bus.capture_state !== st) || (bus.read_index !== ri);
        if (we && ((bus.write_address !== addr) || (bus.write_sample !== data))) bad = 1'b1;
        checks++;
        if (bad) begin
            errors++;
            $display("[TB] FAIL %s: got we=%b addr=%h data=%h st=%b ri=%b, want we=%b addr=%h data=%h st=%b ri=%b",
                     name, bus.write_enable, bus.write_address, bus.write_sample, bus.capture_state,
                     bus.read_index, we, addr, data, st, ri);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        reset                 = 1'b1;
        bus.new_sample_ready  = 1'b0;
        bus.new_sample_in     = '0;
        bus.wave_display_idle = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Ramp samples i<<8 for i in [first, last], expecting consecutive writes in half msb.
    task automatic fillFrame(input logic msb, input int first, input int last, input logic ri);
        logic [7:0] b;
        for (int i = first; i <= last; i++) begin
            b = i[7:0];
            applyStimulus(1'b1, {b, 8'h00}, 1'b0);
            checkOutput("frame_write", 1'b1, {msb, b}, b ^ 8'h80, (i == 255) ? 2'b10 : 2'b01, ri);
        end
    endtask

    // Crossing -5 -> +3, then nwrites-1 ramp samples.
    task automatic captureFrame(input logic msb, input int nwrites, input logic ri);
        applyStimulus(1'b1, 16'hFFFB, 1'b0);
        checkOutput("pre_cross", 1'b0, 9'h000, 8'h00, 2'b00, ri);
        applyStimulus(1'b1, 16'h0003, 1'b0);
        checkOutput("cross_write", 1'b1, {msb, 8'h00}, 8'h80, 2'b01, ri);
        fillFrame(msb, 1, nwrites - 1, ri);
    endtask

    task automatic swapAndHold(input logic new_ri);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkOutput("swap", 1'b0, 9'h000, 8'h00, 2'b00, new_ri);
        for (int i = 0; i < 50; i++) begin
            applyStimulus(1'b0, 16'h0000, 1'b1);
            checkOutput("idle_hold", 1'b0, 9'h000, 8'h00, 2'b00, new_ri);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.new_sample_ready  = 1'b0;
        bus.new_sample_in     = '0;
        bus.wave_display_idle = 1'b0;

        //          rdy   sample     idle  we    addr     data   st     ri
        vecs[0] = '{1'b1, 16'd100,   1'b0, 1'b0, 9'h000, 8'h00, 2'b00, 1'b0};
        vecs[1] = '{1'b1, 16'h0000,  1'b0, 1'b0, 9'h000, 8'h00, 2'b00, 1'b0};
        vecs[2] = '{1'b1, 16'h0001,  1'b0, 1'b0, 9'h000, 8'h00, 2'b00, 1'b0};
        vecs[3] = '{1'b1, 16'hFFFF,  1'b0, 1'b0, 9'h000, 8'h00, 2'b00, 1'b0};
        vecs[4] = '{1'b1, 16'h0000,  1'b0, 1'b1, 9'h100, 8'h80, 2'b01, 1'b0};
        vecs[5] = '{1'b0, 16'h0000,  1'b0, 1'b0, 9'h000, 8'h00, 2'b01, 1'b0};
        vecs[6] = '{1'b1, 16'h8000,  1'b0, 1'b1, 9'h101, 8'h00, 2'b01, 1'b0};
        vecs[7] = '{1'b1, 16'h7FFF,  1'b0, 1'b1, 9'h102, 8'hFF, 2'b01, 1'b0};
        vecs[8] = '{1'b1, 16'hFF00,  1'b0, 1'b1, 9'h103, 8'h7F, 2'b01, 1'b0};
        vecs[9] = '{1'b0, 16'h0000,  1'b1, 1'b0, 9'h000, 8'h00, 2'b01, 1'b0};

        doReset();
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b0, 16'h0000, 1'b0);
            checkOutput("reset_quiet", 1'b0, 9'h000, 8'h00, 2'b00, 1'b0);
        end

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].rdy, vecs[i].smp, vecs[i].idle);
            checkOutput($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].data,
                        vecs[i].st, vecs[i].ri);
        end

        fillFrame(1'b1, 4, 255, 1'b0);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 16'h1234, 1'b0);
            checkOutput("wait_ignores_strobe", 1'b0, 9'h000, 8'h00, 2'b10, 1'b0);
        end

        swapAndHold(1'b1);
        captureFrame(1'b0, 256, 1'b1);
        swapAndHold(1'b0);
        captureFrame(1'b1, 256, 1'b0);
        swapAndHold(1'b1);

        captureFrame(1'b0, 37, 1'b1);
        doReset();
        applyStimulus(1'b0, 16'h0000, 1'b0);
        checkOutput("reset_mid_active", 1'b0, 9'h000, 8'h00, 2'b00, 1'b0);
        captureFrame(1'b1, 3, 1'b0);

`ifdef WAVE_CAPTURE_TIMEOUT_EN
        doReset();
        for (int i = 1; i < 1024; i++) begin
            applyStimulus(1'b1, 16'd7, 1'b0);
            checkOutput("timeout_quiet", 1'b0, 9'h000, 8'h00, 2'b00, 1'b0);
        end
        applyStimulus(1'b1, 16'd7, 1'b0);
        checkOutput("timeout_force", 1'b1, 9'h100, 8'h80, 2'b01, 1'b0);
        fillFrame(1'b1, 1, 255, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
